// File: rtl/crc_frame_controller_pkg.sv
// Shared types and constants for the CRC frame controller and its serializer.
package crc_frame_controller_pkg;

  localparam int CRC_W      = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/crc_frame_controller_if.sv
// Byte stream into the CRC frame controller: valid/ready with end-of-frame marker.
interface crc_frame_controller_if #(
  parameter int BYTE_W = 8
);

  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/crc_byte_serializer.sv
// Holds one byte and walks it out LSB-first, one bit per shift, tracking bit position and end-of-frame.
module crc_byte_serializer #(
  parameter int BYTE_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data,
  input  logic              data_last,
  output logic              lsb,
  output logic              at_last,
  output logic              last
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  logic [BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  assign lsb     = shreg[0];
  assign at_last = (bit_cnt == CNT_W'(BYTE_W - 1));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      last    <= 1'b0;
    end else if (load) begin
      bit_cnt <= '0;
      last    <= data_last;
    end else if (shift) begin
      bit_cnt <= at_last ? '0 : bit_cnt + 1'b1;
    end
  end

  // A reload on the final bit wins over the shift so bytes stream without a gap.
  always_ff @(posedge clk_in) begin
    if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: rtl/crc_frame_controller.sv
// Frames a byte stream onto a bit-serial CRC bank: clears it per frame, shifts bytes in, captures the result.
module crc_frame_controller
  import crc_frame_controller_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_in,
  input  logic              reset_n,
  crc_frame_controller_if.slave s,
  input  logic              abort,
  input  logic [CRC_W-1:0]  bank_crc,
  output logic              bank_in_data,
  output logic              bank_en,
  output logic              bank_clr_n,
  output logic [CRC_W-1:0]  crc_value,
  output logic              crc_zero,
  output logic [LEN_W-1:0]  frame_bytes,
  output logic              crc_valid,
  output logic              busy
);

  state_t           state;
  logic             frame_open;
  logic [LEN_W-1:0] byte_cnt;
  logic             ser_lsb;
  logic             ser_at_last;
  logic             ser_last;
  logic             ready;
  logic             xfer;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Ready and bank controls decode registered state only; abort swallows a coincident transfer.
  assign ready        = (state == ST_IDLE) ||
                        ((state == ST_SHIFT) && ser_at_last && !ser_last);
  assign s.s_ready    = ready;
  assign xfer         = s.s_valid && ready && !abort;
  assign bank_en      = (state == ST_SHIFT);
  assign bank_in_data = bank_en & ser_lsb;
  assign busy         = (state != ST_IDLE);

  crc_byte_serializer #(
    .BYTE_W (BYTE_W)
  ) u_serializer (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .load      (xfer),
    .shift     (bank_en),
    .data      (s.s_data),
    .data_last (s.s_last),
    .lsb       (ser_lsb),
    .at_last   (ser_at_last),
    .last      (ser_last)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      frame_open  <= 1'b0;
      byte_cnt    <= '0;
      bank_clr_n  <= 1'b0;
      crc_value   <= '0;
      crc_zero    <= 1'b0;
      frame_bytes <= '0;
      crc_valid   <= 1'b0;
    end else begin
      crc_valid  <= 1'b0;
      bank_clr_n <= 1'b1;
      if (abort) begin
        state      <= ST_IDLE;
        frame_open <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (xfer) begin
              frame_open <= 1'b1;
              if (!frame_open) begin
                state      <= ST_CLEAR;
                bank_clr_n <= 1'b0;
                byte_cnt   <= LEN_W'(1);
              end else begin
                state    <= ST_SHIFT;
                byte_cnt <= sat_inc(byte_cnt);
              end
            end
          end
          ST_CLEAR: state <= ST_SHIFT;
          ST_SHIFT: begin
            if (ser_at_last) begin
              if (ser_last) begin
                state <= ST_DONE;
              end else if (xfer) begin
                byte_cnt <= sat_inc(byte_cnt);
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_DONE: begin
            crc_value   <= bank_crc;
            crc_zero    <= (bank_crc == '0);
            frame_bytes <= byte_cnt;
            crc_valid   <= 1'b1;
            frame_open  <= 1'b0;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_controller.sv
// Directed bench for crc_frame_controller driving a bit-serial reflected CRC-32 bank model.
module tb_crc_frame_controller;
  import crc_frame_controller_pkg::*;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 4;
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic              clk_in  = 1'b0;
  logic              reset_n = 1'b0;
  logic              abort   = 1'b0;
  logic [31:0]       bank_crc;
  logic              bank_in_data, bank_en, bank_clr_n;
  logic [31:0]       crc_value;
  logic              crc_zero, crc_valid, busy;
  logic [LEN_W-1:0]  frame_bytes;

  int n_chk, n_err, cyc;
  int en_cnt, run, max_run, vld_cnt, vld_cyc, clr_cnt;
  int t1, t2, t3;

  crc_frame_controller_if #(.BYTE_W(BYTE_W)) s_if ();

  crc_frame_controller #(
    .BYTE_W (BYTE_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .s            (s_if),
    .abort        (abort),
    .bank_crc     (bank_crc),
    .bank_in_data (bank_in_data),
    .bank_en      (bank_en),
    .bank_clr_n   (bank_clr_n),
    .crc_value    (crc_value),
    .crc_zero     (crc_zero),
    .frame_bytes  (frame_bytes),
    .crc_valid    (crc_valid),
    .busy         (busy)
  );

  always #5 clk_in = ~clk_in;

  // Bit-serial reflected CRC bank: new bit enters at the MSB, feedback from the bit leaving the LSB.
  always_ff @(posedge clk_in) begin
    if (!bank_clr_n) begin
      bank_crc <= '0;
    end else if (bank_en) begin
      bank_crc <= {bank_in_data, bank_crc[31:1]} ^ (bank_crc[0] ? POLY : 32'h0);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (bank_en) begin
      en_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (crc_valid) begin
      vld_cnt++;
      vld_cyc = cyc;
    end
    if (!bank_clr_n && reset_n) clr_cnt++;
  endtask

  task automatic clear_stats();
    en_cnt = 0; run = 0; max_run = 0; vld_cnt = 0; vld_cyc = -1; clr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic hold, output int t);
    s_if.s_data  = d;
    s_if.s_valid = 1'b1;
    s_if.s_last  = last;
    t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      if (s_if.s_ready) t = cyc;
      tick();
    end
    if (t < 0) check("xfer_timeout", 64'(t), 64'(0));
    if (!hold) s_if.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && vld_cnt == 0; i++) tick();
    if (vld_cnt == 0) check("valid_timeout", 64'(vld_cnt), 64'(1));
  endtask

  task automatic single_frame(input string tag, input logic [7:0] d, input logic [31:0] exp_crc);
    clear_stats();
    send_byte(d, 1'b1, 1'b0, t1);
    wait_valid(30);
    repeat (3) tick();
    check({tag, "_crc"},  64'(crc_value), 64'(exp_crc));
    check({tag, "_zero"}, 64'(crc_zero),  64'(exp_crc == 32'h0));
    check({tag, "_len"},  64'(frame_bytes), 64'(1));
    check({tag, "_en"},   64'(en_cnt), 64'(8));
    check({tag, "_lat"},  64'(vld_cyc - t1), 64'(11));
    check({tag, "_vld"},  64'(vld_cnt), 64'(1));
    check({tag, "_clr"},  64'(clr_cnt), 64'(1));
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    s_if.s_data = '0; s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
    clear_stats();

    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(s_if.s_ready), 64'(1));
    check("rst_en",    64'(bank_en), 64'(0));
    check("rst_bit",   64'(bank_in_data), 64'(0));
    check("rst_clr",   64'(bank_clr_n), 64'(0));
    check("rst_crc",   64'(crc_value), 64'(0));
    check("rst_zero",  64'(crc_zero), 64'(0));
    check("rst_len",   64'(frame_bytes), 64'(0));
    check("rst_vld",   64'(crc_valid), 64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_bank",  64'(bank_crc), 64'(0));
    reset_n = 1'b1;
    tick();
    check("rel_clr", 64'(bank_clr_n), 64'(1));

    single_frame("b00", 8'h00, 32'h00000000);
    single_frame("b01", 8'h01, 32'h01000000);
    single_frame("b80", 8'h80, 32'h80000000);

    // Two bytes streamed back-to-back
    clear_stats();
    send_byte(8'h01, 1'b0, 1'b1, t1);
    send_byte(8'h00, 1'b1, 1'b0, t2);
    wait_valid(40);
    check("b2b_gap", 64'(t2 - t1), 64'(9));
    check("b2b_run", 64'(max_run), 64'(16));
    check("b2b_en",  64'(en_cnt), 64'(16));
    check("b2b_crc", 64'(crc_value), 64'(32'h00010000));
    check("b2b_len", 64'(frame_bytes), 64'(2));

    // Abort mid-shift of an open frame, then a fresh frame
    clear_stats();
    send_byte(8'h01, 1'b0, 1'b0, t1);
    repeat (3) tick();
    check("abt_busy_pre", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_en",   64'(bank_en), 64'(0));
    check("abt_busy", 64'(busy), 64'(0));
    repeat (12) tick();
    check("abt_novld",    64'(vld_cnt), 64'(0));
    check("abt_hold_crc", 64'(crc_value), 64'(32'h00010000));
    check("abt_hold_len", 64'(frame_bytes), 64'(2));
    s_if.s_data = 8'h55; s_if.s_last = 1'b1; s_if.s_valid = 1'b1; abort = 1'b1;
    tick();
    s_if.s_valid = 1'b0; abort = 1'b0;
    check("abt_xfer_drop", 64'(busy), 64'(0));
    clear_stats();
    send_byte(8'h00, 1'b1, 1'b0, t1);
    wait_valid(30);
    check("abt_new_clr", 64'(clr_cnt), 64'(1));
    check("abt_new_crc", 64'(crc_value), 64'(0));
    check("abt_new_len", 64'(frame_bytes), 64'(1));
    check("abt_new_vld", 64'(vld_cnt), 64'(1));

    // Asynchronous reset during the third byte
    clear_stats();
    send_byte(8'hFF, 1'b0, 1'b1, t1);
    send_byte(8'hFF, 1'b0, 1'b1, t2);
    send_byte(8'hFF, 1'b0, 1'b0, t3);
    repeat (3) tick();
    check("mid_busy_pre", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("mid_busy",  64'(busy), 64'(0));
    check("mid_en",    64'(bank_en), 64'(0));
    check("mid_bit",   64'(bank_in_data), 64'(0));
    check("mid_clr",   64'(bank_clr_n), 64'(0));
    check("mid_ready", 64'(s_if.s_ready), 64'(1));
    check("mid_crc",   64'(crc_value), 64'(0));
    check("mid_zero",  64'(crc_zero), 64'(0));
    check("mid_len",   64'(frame_bytes), 64'(0));
    tick();
    check("mid_bank", 64'(bank_crc), 64'(0));
    check("mid_novld", 64'(vld_cnt), 64'(0));
    reset_n = 1'b1;
    tick();
    single_frame("post_rst", 8'h80, 32'h80000000);

    // Twenty zero bytes saturate a 4-bit length counter
    clear_stats();
    for (int i = 0; i < 20; i++) send_byte(8'h00, (i == 19), (i < 19), t1);
    wait_valid(40);
    check("sat_len",  64'(frame_bytes), 64'(15));
    check("sat_crc",  64'(crc_value), 64'(0));
    check("sat_zero", 64'(crc_zero), 64'(1));
    check("sat_en",   64'(en_cnt), 64'(160));
    check("sat_run",  64'(max_run), 64'(160));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/crc_frame_controller.md
# crc_frame_controller

Sequences the bit-serial 32-bit CRC shift register bank over byte-framed data. It accepts bytes on a valid/ready stream and clears the bank at start of frame. It serializes each byte LSB-first into the bank with one enable per bit, then captures and reports the final CRC and the frame length. It sits between the frame receive path and the CRC bank instance.

## Interface
- BYTE_W, 8, bits per accepted data word; bit counter is clog2(BYTE_W) wide
- LEN_W, 16, width of frame byte counter
- clk_in  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_data  in  BYTE_W  data byte
- s_valid  in  1  s_data/s_last valid
- s_last  in  1  byte is last of frame
- s_ready  out  1  controller accepts byte this cycle
- abort  in  1  synchronous frame abort
- bank_crc  in  32  current CRC bank contents
- bank_in_data  out  1  serial bit to bank
- bank_en  out  1  bank shift enable
- bank_clr_n  out  1  active-low clear to bank, registered
- crc_value  out  32  captured CRC of last completed frame
- crc_zero  out  1  captured CRC == 0
- frame_bytes  out  LEN_W  byte count of last completed frame, saturating
- crc_valid  out  1  one-cycle pulse: crc_value/crc_zero/frame_bytes updated
- busy  out  1  frame in progress (state != IDLE)

## Operation
- States: IDLE, CLEAR, SHIFT, DONE.
- Transfer occurs when s_valid && s_ready. On transfer, latch s_data into shift reg, latch s_last, increment byte count. The count saturates at 2^LEN_W-1.
- IDLE: s_ready=1. On transfer:
  - If no frame is open: go CLEAR, drive bank_clr_n low for the CLEAR cycle, reset byte count to 1.
  - If a frame is open: go SHIFT.
- CLEAR: one cycle, then SHIFT with bit_cnt=0.
- SHIFT: bank_en=1, bank_in_data=shreg[0]. Each cycle shift shreg right and increment bit_cnt.
  - At bit_cnt==BYTE_W-1 with latched last=0: s_ready=1. A transfer in that cycle reloads shreg and stays in SHIFT with bit_cnt=0 (back-to-back, BYTE_W cycles/byte). No transfer: go IDLE, frame stays open.
  - At bit_cnt==BYTE_W-1 with last=1: go DONE, s_ready=0.
- DONE: one cycle. At its end register crc_value<=bank_crc, crc_zero<=(bank_crc==0), frame_bytes<=count, and crc_valid<=1. Close the frame and go IDLE.
- abort (any state, highest priority): go IDLE and close the frame. No crc_valid. Captured outputs hold. bank_en=0 from the next cycle. A transfer coincident with abort is discarded.
- The next frame's first byte always forces CLEAR, so stale bank contents never leak between frames.

## Timing
- Reset values:
  - state=IDLE, s_ready=1 (decoded), bank_en=0, bank_in_data=0.
  - bank_clr_n=0, so the bank is cleared during reset; it is 1 from the first clock after release.
  - crc_value=0, crc_zero=0, frame_bytes=0, crc_valid=0, busy=0.
- bank_en, bank_in_data, bank_clr_n are decoded only from registers. There is no combinational path from s_* to the bank.
- s_ready depends only on registered state/bit_cnt/last, not on s_valid.
- Latency for a single-byte frame, transfer at cycle T:
  - CLEAR at T+1.
  - SHIFT at T+2..T+1+BYTE_W.
  - DONE at T+2+BYTE_W.
  - crc_valid high at T+3+BYTE_W.
- Each additional byte adds BYTE_W cycles when streamed back-to-back.
- Asynchronous reset mid-frame drops the frame with no crc_valid, and the bank is cleared via bank_clr_n.

## Structure
- Shared package holds the state enum (IDLE/CLEAR/SHIFT/DONE), the CRC width constant 32, and the LEN_W default.
- One sub-module is natural: crc_byte_serializer, holding the shift register, bit counter and last flag, with load/shift/at_last handshake. The FSM, counters and capture stay in the top.
- The bench instantiates the real CRC bank wired to bank_* ports. reset_n gates the bank only through bank_clr_n.

## Test plan
- Single-byte frame 0x00 with s_last=1 -> exactly 8 bank_en cycles, crc_valid at T+11, crc_value=0x00000000, crc_zero=1, frame_bytes=1.
- Single byte 0x01 -> crc_value=0x01000000, crc_zero=0. Single byte 0x80 -> crc_value=0x80000000.
- Frame 0x01,0x00 with s_valid held high -> s_ready pulses on the 8th shift cycle, bank_en stays high for 16 contiguous cycles, crc_value=0x00010000, frame_bytes=2.
- Frame 0x01 (no last), then abort mid-SHIFT, then new frame 0x00 last -> no crc_valid for the aborted frame. CLEAR seen for the new frame, crc_value=0x00000000, frame_bytes=1.
- reset_n low during SHIFT of byte 3 -> all outputs at reset values, bank_clr_n=0 during reset. The next frame 0x80 yields 0x80000000.
- LEN_W=4 and a 20-byte all-zero frame -> frame_bytes=15 (saturated), crc_value=0.
